// File: rtl/blk_mem_pkg.sv
// blk_mem_pkg: shared constants and elaboration-time helpers for the block memory controller.
// Latency: none; this package holds only parameters and constant functions.
// Backpressure: none; it is used by blk_mem_ctrl and blk_mem_rsp_buf.
package blk_mem_pkg;

  localparam int RD_LAT_MAX = 2;

  // Ceiling log2 with a floor of 1, so a one-entry structure still gets a real bit.
  function automatic int clog2(input int n);
    int r;
    longint v;
    r = 0;
    v = 1;
    while (v < longint'(n)) begin
      v = v * 2;
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Number of byte lanes in a data word.
  function automatic int lanes(input int data_w);
    return data_w / 8;
  endfunction

  // True when the parameter set describes a buildable controller.
  function automatic bit params_ok(input int data_w, input int addr_w,
                                   input int depth, input int rd_lat);
    bit ok;
    ok = 1'b1;
    if (data_w < 8 || (data_w % 8) != 0) ok = 1'b0;
    if (addr_w < 1 || addr_w > 30) ok = 1'b0;
    if (depth < 1) ok = 1'b0;
    if (addr_w >= 1 && addr_w <= 30 && longint'(depth) > (longint'(1) << addr_w)) ok = 1'b0;
    if (rd_lat < 1 || rd_lat > RD_LAT_MAX) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/blk_mem_rsp_buf.sv
// blk_mem_rsp_buf: count-based circular response buffer; pointers wrap modulo DEPTH (any depth).
// Latency: a push is visible at the head on the next cycle when the buffer was empty.
// Backpressure: the owner guarantees space via credits; a push into a full buffer is only taken with a same-cycle pop.
module blk_mem_rsp_buf
  import blk_mem_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_dat,
  input  logic             pop,
  output logic [W-1:0]     head_dat,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = clog2(DEPTH);

  logic [W-1:0]     slot [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Advance a pointer, wrapping at DEPTH-1 rather than at a power of two.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Qualify push/pop against the occupancy count; full/empty never use pointer compare.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  end

  // Storage, pointers and count; slots are cleared so the head reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
    end else begin
      if (do_push) begin
        slot[wr_ptr] <= push_dat;
        wr_ptr       <= bump(wr_ptr);
      end
      if (do_pop) rd_ptr <= bump(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign head_dat = slot[rd_ptr];

endmodule

// File: rtl/blk_mem_ctrl.sv
// blk_mem_ctrl: byte-writable word memory with valid/ready request and response channels.
// Latency: read data appears RD_LAT cycles after accept when the response buffer is empty; writes land at the accept edge.
// Backpressure: req_ready drops at RD_LAT+1 outstanding reads unless a response pops that cycle; BLK_MEM_RANGE_ERR_EN adds rsp_err/wr_err.
module blk_mem_ctrl
  import blk_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 1
) (
  input  logic                clka,
  input  logic                rsta,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_W/8-1:0] req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
`ifdef BLK_MEM_RANGE_ERR_EN
  output logic                rsp_err,
  output logic                wr_err,
`endif
  output logic                busy
);

  localparam int LANES = lanes(DATA_W);
  localparam int IDX_W = clog2(DEPTH);
  localparam int BUF_D = RD_LAT + 1;
  localparam int CNT_W = clog2(BUF_D + 1);
`ifdef BLK_MEM_RANGE_ERR_EN
  localparam int BUF_W = DATA_W + 1;
`else
  localparam int BUF_W = DATA_W;
`endif
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  if (!params_ok(DATA_W, ADDR_W, DEPTH, RD_LAT)) begin : g_param_err
    $error("blk_mem_ctrl: illegal DATA_W/ADDR_W/DEPTH/RD_LAT combination");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc_rd;
  logic              acc_wr;
  logic              pop;
  logic              in_range;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] rd_word;
  logic [BUF_W-1:0]  rd_entry;
  logic              push;
  logic [BUF_W-1:0]  push_dat;
  logic [BUF_W-1:0]  head_dat;
  logic [CNT_W-1:0]  buf_cnt;
  logic [CNT_W-1:0]  n_q;

  // Handshake decode and array lookup; out-of-range reads yield zero with normal timing.
  always_comb begin
    pop       = rsp_valid && rsp_ready;
    req_ready = !rsta && ((n_q < CNT_W'(BUF_D)) || pop);
    acc_rd    = req_valid && req_ready && (req_we == '0);
    acc_wr    = req_valid && req_ready && (req_we != '0);
    in_range  = ({1'b0, req_addr} < DEPTH_L);
    mem_idx   = req_addr[IDX_W-1:0];
    rd_word   = in_range ? mem[mem_idx] : '0;
`ifdef BLK_MEM_RANGE_ERR_EN
    rd_entry  = {~in_range, rd_word};
`else
    rd_entry  = rd_word;
`endif
  end

  // Byte-lane writes; the array is deliberately not reset so contents survive rsta.
  always_ff @(posedge clka) begin
    if (acc_wr && in_range) begin
      for (int b = 0; b < LANES; b++) begin
        if (req_we[b]) mem[mem_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
      end
    end
  end

  if (RD_LAT == 2) begin : g_pipe2
    logic             p_vld;
    logic [BUF_W-1:0] p_dat;

    // One extra in-flight stage between the array and the response buffer.
    always_ff @(posedge clka) begin
      if (rsta) begin
        p_vld <= 1'b0;
      end else begin
        p_vld <= acc_rd;
        if (acc_rd) p_dat <= rd_entry;
      end
    end

    assign push     = p_vld;
    assign push_dat = p_dat;
  end else begin : g_pipe1
    assign push     = acc_rd;
    assign push_dat = rd_entry;
  end

  // Outstanding-read credit count: reads in the pipe plus entries held in the buffer.
  always_ff @(posedge clka) begin
    if (rsta) n_q <= '0;
    else      n_q <= n_q + CNT_W'(acc_rd) - CNT_W'(pop);
  end

  blk_mem_rsp_buf #(
    .W     (BUF_W),
    .DEPTH (BUF_D),
    .CNT_W (CNT_W)
  ) u_rsp_buf (
    .clk      (clka),
    .rst      (rsta),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (buf_cnt)
  );

  assign rsp_valid = (buf_cnt != '0);
  assign rsp_rdata = head_dat[DATA_W-1:0];
  assign busy      = (n_q != '0);

`ifdef BLK_MEM_RANGE_ERR_EN
  assign rsp_err = head_dat[DATA_W];

  // Sticky flag for a dropped out-of-range write; only rsta clears it.
  always_ff @(posedge clka) begin
    if (rsta)                       wr_err <= 1'b0;
    else if (acc_wr && !in_range)   wr_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_blk_mem_ctrl.sv
// tb_blk_mem_ctrl: directed stimulus with a response scoreboard for blk_mem_ctrl.
// Latency: expects read data RD_LAT cycles after accept when the buffer is empty.
// Backpressure: exercises rsp_ready low to exhaust credits; BLK_MEM_RANGE_ERR_EN adds error-flag checks.
module tb_blk_mem_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 3000;
  localparam int RD_LAT = 2;

  logic              clka = 1'b0;
  logic              rsta = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [3:0]        req_we = '0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
`ifdef BLK_MEM_RANGE_ERR_EN
  logic              rsp_err;
  logic              wr_err;
`endif

  blk_mem_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clka      (clka),
    .rsta      (rsta),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
`ifdef BLK_MEM_RANGE_ERR_EN
    .rsp_err   (rsp_err),
    .wr_err    (wr_err),
`endif
    .busy      (busy)
  );

  always #5 clka = ~clka;

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drive one request and hold it until accepted; reads push their expected response.
  task automatic send(input logic [3:0] we, input logic [ADDR_W-1:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e,
                      input bit track, input bit chk_lat, output int waited);
    exp_t e;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    waited    = 0;
    @(negedge clka);
    while (!req_ready && waited < 40) begin
      waited++;
      @(negedge clka);
    end
    if (!req_ready) begin
      n_chk++;
      $display("FAIL req_timeout: addr %0h not accepted within 40 cycles", addr);
    end else if (we == 4'b0000 && track) begin
      e.dat     = exp_d;
      e.err     = exp_e;
      e.acc_cyc = cyc;
      e.chk_lat = chk_lat;
      q.push_back(e);
    end
    @(posedge clka);
    #1;
    req_valid = 1'b0;
    req_we    = '0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] addr, input logic [31:0] wd, input logic [3:0] we);
    int w;
    send(we, addr, wd, 32'h0, 1'b0, 1'b0, 1'b0, w);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] addr, input logic [31:0] exp_d,
                    input logic exp_e, input bit chk_lat, output int waited);
    send(4'b0000, addr, 32'h0, exp_d, exp_e, 1'b1, chk_lat, waited);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(posedge clka);
      t++;
    end
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d responses still expected", q.size());
    end
    @(posedge clka);
    #1;
  endtask

  // Monitor: pops the scoreboard on each response transfer and checks hold stability.
  bit          prev_vld = 1'b0;
  bit          prev_rdy = 1'b0;
  bit          prev_rst = 1'b1;
  logic [31:0] prev_dat = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clka);
      if (prev_vld && !prev_rdy && !prev_rst) begin
        chk("hold_valid", 64'(rsp_valid), 64'd1);
        chk("hold_rdata", 64'(rsp_rdata), 64'(prev_dat));
      end
      if (rsp_valid && rsp_ready && !rsta) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_rsp: rdata %0h with empty scoreboard", rsp_rdata);
        end else begin
          e = q.pop_front();
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.dat));
`ifdef BLK_MEM_RANGE_ERR_EN
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
`endif
          if (e.chk_lat) chk("rsp_latency", 64'(cyc - e.acc_cyc), 64'(RD_LAT));
        end
      end
      prev_vld = rsp_valid;
      prev_rdy = rsp_ready;
      prev_rst = rsta;
      prev_dat = rsp_rdata;
    end
  end

  initial begin
    int w;
    bit seen;

    // Reset state.
    repeat (2) @(negedge clka);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clka);
    #1;
    rsta = 1'b0;
    @(negedge clka);
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    @(posedge clka);
    #1;

    // Preload words 0..15 with 0x100+a.
    for (int a = 0; a < 16; a++) wr(ADDR_W'(a), 32'h100 + 32'(a), 4'b1111);
`ifdef BLK_MEM_RANGE_ERR_EN
    chk("wr_err_clean", 64'(wr_err), 64'd0);
`endif

    // Back-pressure: three reads fill the credits, the fourth waits.
    rsp_ready = 1'b0;
    for (int a = 0; a < 3; a++) begin
      rd(ADDR_W'(a), 32'h100 + 32'(a), 1'b0, 1'b0, w);
      chk("bp_accept_wait", 64'(w), 64'd0);
    end
    req_valid = 1'b1;
    req_we    = 4'b0000;
    req_addr  = ADDR_W'(3);
    repeat (3) @(negedge clka);
    chk("bp_full_ready", 64'(req_ready), 64'd0);
    chk("bp_full_busy", 64'(busy), 64'd1);
    chk("bp_head_valid", 64'(rsp_valid), 64'd1);
    @(posedge clka);
    #1;
    rsp_ready = 1'b1;
    rd(ADDR_W'(3), 32'h103, 1'b0, 1'b0, w);
    chk("bp_resume_wait", 64'(w), 64'd0);
    rd(ADDR_W'(4), 32'h104, 1'b0, 1'b0, w);
    drain();

    // Streaming: 16 back-to-back reads with rsp_ready high.
    for (int a = 0; a < 16; a++) begin
      rd(ADDR_W'(a), 32'h100 + 32'(a), 1'b0, 1'b1, w);
      chk("stream_ready", 64'(w), 64'd0);
    end
    repeat (3) @(negedge clka);
    chk("stream_busy_done", 64'(busy), 64'd0);
    chk("stream_queue_empty", 64'(q.size()), 64'd0);
    @(posedge clka);
    #1;

    // Byte-lane merge on address 5.
    wr(ADDR_W'(5), 32'h11223344, 4'b1111);
    wr(ADDR_W'(5), 32'hAABBCCDD, 4'b0010);
    rd(ADDR_W'(5), 32'h1122CC44, 1'b0, 1'b1, w);

    // Write then read on the very next cycle.
    wr(ADDR_W'(7), 32'hDEADBEEF, 4'b1111);
    rd(ADDR_W'(7), 32'hDEADBEEF, 1'b0, 1'b1, w);
    drain();

    // Out of range: address 3500 is dropped and reads zero; 3500-DEPTH stays intact.
    wr(ADDR_W'(500), 32'h55667788, 4'b1111);
    wr(ADDR_W'(3500), 32'hCAFEF00D, 4'b1111);
    rd(ADDR_W'(3500), 32'h0, 1'b1, 1'b1, w);
    rd(ADDR_W'(500), 32'h55667788, 1'b0, 1'b1, w);
    drain();
`ifdef BLK_MEM_RANGE_ERR_EN
    chk("wr_err_set", 64'(wr_err), 64'd1);
    repeat (2) @(posedge clka);
    #1;
    chk("wr_err_sticky", 64'(wr_err), 64'd1);
`endif

    // Reset with two reads in flight: they must vanish.
    rsp_ready = 1'b0;
    send(4'b0000, ADDR_W'(1), 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, w);
    send(4'b0000, ADDR_W'(2), 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, w);
    rsta = 1'b1;
    @(negedge clka);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    @(posedge clka);
    #1;
    rsta      = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clka);
    chk("midrst_ready_after", 64'(req_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_rsp_rdata", 64'(rsp_rdata), 64'd0);
`ifdef BLK_MEM_RANGE_ERR_EN
    chk("midrst_wr_err", 64'(wr_err), 64'd0);
`endif
    seen = rsp_valid;
    repeat (6) begin
      @(negedge clka);
      seen = seen | rsp_valid;
    end
    chk("midrst_no_rsp", 64'(seen), 64'd0);
    @(posedge clka);
    #1;
    rd(ADDR_W'(7), 32'hDEADBEEF, 1'b0, 1'b1, w);
    rd(ADDR_W'(5), 32'h1122CC44, 1'b0, 1'b1, w);
    drain();
    chk("final_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
